pool_window_gen: RTL and testbench
==================================

Name: pool_window_gen

Overview:
Upstream feeder for the 2x2 average-pool stage. Accepts a raster-order pixel stream (one pixel per clk when in_valid) and emits non-overlapping 2x2, stride-2 windows on pixel1..pixel4, the same four-pixel interface the avgpool stage consumes. One row of pixels is buffered internally. There is no backpressure, because the pool stage is always ready.

Parameters:
PIX_W, 4, pixel bit width (matches the pool stage)
IMG_W, 8, image width in pixels; must be even and >= 2
IMG_H, 8, image height in pixels; must be even and >= 2

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  in_pixel carries a valid pixel this cycle
in_pixel  in  PIX_W  pixel value, raster order (row-major, left to right)
out_valid  out  1  window on pixel1..pixel4 is valid, one-cycle pulse per window
pixel1  out  PIX_W  window top-left
pixel2  out  PIX_W  window top-right
pixel3  out  PIX_W  window bottom-left
pixel4  out  PIX_W  window bottom-right
out_x  out  clog2(IMG_W/2) (min 1)  window column index
out_y  out  clog2(IMG_H/2) (min 1)  window row index
frame_done  out  1  pulses together with the last window of a frame

Behaviour:
- Reset (async assert, sync deassert at the pool-stage level): col=0, row=0, out_valid=0, frame_done=0, pixel1..4=0, out_x=0, out_y=0, left-hold register=0. Line buffer contents are not reset; every entry is written on an even row before it is read.
- Counters advance only on in_valid. Gaps of any length are allowed, and all state holds during a gap.
- col wraps IMG_W-1 -> 0 and increments row. row wraps IMG_H-1 -> 0, which starts the next frame with no idle cycle required.
- Row phase acts as a 2-state FSM on row[0]:
  - EVEN_ROW: each accepted pixel is written to linebuf[col].
  - ODD_ROW: linebuf is read only. When col is even, in_pixel is captured into the left-hold register.
- Window emit on an accepted pixel with row odd and col odd. On the next clk edge (latency 1):
  - pixel1 = linebuf[col-1]
  - pixel2 = linebuf[col]
  - pixel3 = left-hold
  - pixel4 = in_pixel
  - out_x = col>>1, out_y = row>>1
  - out_valid = 1
- out_valid is high for exactly one cycle per window. pixel*/out_x/out_y hold their last values while out_valid=0.
- frame_done = 1 in the same cycle as out_valid for the window with out_x = IMG_W/2-1 and out_y = IMG_H/2-1. It is 0 otherwise.
- Windows per frame: (IMG_W/2)*(IMG_H/2). Pixel values pass through unmodified, with no arithmetic.
- Reset asserted mid-frame: the partial frame is discarded, and the next accepted pixel is treated as (row 0, col 0).
- A pixel accepted in the same cycle that rst is high is ignored.

Decomposition:
- Shared package cnn_pkg: PIX_W constant and the pixel typedef/width, shared with avgpool and later CNN stages.
- Sub-module line_buffer (IMG_W x PIX_W):
  - synchronous write with wr_en and wr_addr
  - combinational read with rd_addr, two read ports (col-1, col)
- The counter/FSM and output registers stay in pool_window_gen.

Test Plan:
- IMG_W=4, IMG_H=4, in_valid continuous, pixels 0..15 -> exactly 4 out_valid pulses:
  - (0,1,4,5) at x0 y0
  - (2,3,6,7) at x1 y0
  - (8,9,12,13) at x0 y1
  - (10,11,14,15) at x1 y1, with frame_done=1
  - each pulse appears one cycle after pixels 5/7/13/15 are accepted.
- Same stream with in_valid=0 for 3 cycles after every 2nd pixel -> identical window values and order; out_valid pulses are each 1 cycle wide.
- Two back-to-back frames, second frame = 15 minus first (values 15..0) -> second frame windows are (15,14,11,10), (13,12,9,8), (7,6,3,2), (5,4,1,0); frame_done pulses twice total.
- After reset, outputs are all 0 with no stimulus. Then rst asserted for 1 cycle after 6 pixels, followed by a full frame of 0..15 -> no window emitted before the reset; post-reset windows match scenario 1.
- Default IMG_W=8, IMG_H=8, all pixels = 4'hF -> 16 windows, all pixel1..4 = 15; out_x cycles 0..3 for each out_y 0..3; frame_done is seen only on (3,3).

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: pixel width, pixel type and helpers shared by the pooling front end and later CNN stages.
package cnn_pkg;
    localparam int PIX_W = 4;
    typedef logic [PIX_W-1:0] pixel_t;
    typedef enum logic {EVEN_ROW = 1'b0, ODD_ROW = 1'b1} row_phase_e;
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/line_buffer.sv
// line_buffer: one image row of pixels, synchronous write, two combinational read ports.
module line_buffer #(
    parameter int W = cnn_pkg::PIX_W,
    parameter int DEPTH = 8,
    localparam int AW = cnn_pkg::clog2_min1(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [W-1:0]  rd_data_a,
    output logic [W-1:0]  rd_data_b
);
    logic [W-1:0] mem [DEPTH];
    // Not reset: every entry is rewritten on an even row before the odd row reads it.
    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data;
    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];
endmodule

// File: rtl/pool_window_gen.sv
// pool_window_gen: turns a raster pixel stream into non-overlapping 2x2 stride-2 windows for avgpool.
module pool_window_gen #(
    parameter int PIX_W = cnn_pkg::PIX_W,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    localparam int CW = cnn_pkg::clog2_min1(IMG_W),
    localparam int RW = cnn_pkg::clog2_min1(IMG_H),
    localparam int XW = cnn_pkg::clog2_min1(IMG_W / 2),
    localparam int YW = cnn_pkg::clog2_min1(IMG_H / 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    output logic [PIX_W-1:0] pixel1,
    output logic [PIX_W-1:0] pixel2,
    output logic [PIX_W-1:0] pixel3,
    output logic [PIX_W-1:0] pixel4,
    output logic [XW-1:0]    out_x,
    output logic [YW-1:0]    out_y,
    output logic             frame_done
);
    cnn_pkg::row_phase_e phase_q, phase_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [PIX_W-1:0] hold_q, hold_d;
    logic [PIX_W-1:0] p1_q, p2_q, p3_q, p4_q, rd_a, rd_b;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic             valid_q, done_q, col_last, row_last, emit;

    always_comb begin
        col_last = col_q == CW'(IMG_W - 1);
        row_last = row_q == RW'(IMG_H - 1);
        emit     = in_valid && phase_q == cnn_pkg::ODD_ROW && col_q[0];
        col_d    = col_q;
        row_d    = row_q;
        phase_d  = phase_q;
        hold_d   = hold_q;
        if (in_valid) begin
            col_d   = col_last ? '0 : col_q + 1'b1;
            row_d   = !col_last ? row_q : row_last ? '0 : row_q + 1'b1;
            phase_d = !col_last ? phase_q
                    : phase_q == cnn_pkg::EVEN_ROW ? cnn_pkg::ODD_ROW : cnn_pkg::EVEN_ROW;
            hold_d  = (phase_q == cnn_pkg::ODD_ROW && !col_q[0]) ? in_pixel : hold_q;
        end
    end

    line_buffer #(.W(PIX_W), .DEPTH(IMG_W)) u_lb (
        .clk       (clk),
        .wr_en     (in_valid && !rst && phase_q == cnn_pkg::EVEN_ROW),
        .wr_addr   (col_q),
        .wr_data   (in_pixel),
        .rd_addr_a (col_q - 1'b1),
        .rd_addr_b (col_q),
        .rd_data_a (rd_a),
        .rd_data_b (rd_b)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            phase_q <= cnn_pkg::EVEN_ROW;
            col_q   <= '0;
            row_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            {p1_q, p2_q, p3_q, p4_q} <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            phase_q <= phase_d;
            col_q   <= col_d;
            row_q   <= row_d;
            hold_q  <= hold_d;
            valid_q <= emit;
            done_q  <= emit && col_last && row_last;
            // Window fields hold their last value between pulses.
            if (emit) begin
                p1_q <= rd_a;
                p2_q <= rd_b;
                p3_q <= hold_q;
                p4_q <= in_pixel;
                x_q  <= XW'(col_q >> 1);
                y_q  <= YW'(row_q >> 1);
            end
        end

    assign out_valid  = valid_q;
    assign frame_done = done_q;
    assign pixel1     = p1_q;
    assign pixel2     = p2_q;
    assign pixel3     = p3_q;
    assign pixel4     = p4_q;
    assign out_x      = x_q;
    assign out_y      = y_q;
endmodule

// File: tb/tb_pool_window_gen.sv
// tb_pool_window_gen: directed checks of a 4x4 and a default 8x8 window generator.
module tb_pool_window_gen;
    typedef struct {
        logic [3:0] p1, p2, p3, p4;
        int         x, y;
        logic       fd;
    } win_t;

    logic clk = 1'b0, rst = 1'b1;
    logic v4 = 1'b0, v8 = 1'b0;
    logic [3:0] px4 = '0, px8 = '0;
    logic ov4, fd4, ov8, fd8;
    logic [3:0] a1, a2, a3, a4, b1, b2, b3, b4;
    logic [0:0] x4, y4;
    logic [1:0] x8, y8;
    int vectors = 0, miscompares = 0;
    win_t q4[$], q8[$];
    int run4 = 0, run8 = 0, max4 = 0, max8 = 0, fdc4 = 0, fdc8 = 0;
    win_t exp1[4];

    always #5 clk = ~clk;

    pool_window_gen #(.PIX_W(4), .IMG_W(4), .IMG_H(4)) d4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_pixel(px4), .out_valid(ov4),
        .pixel1(a1), .pixel2(a2), .pixel3(a3), .pixel4(a4),
        .out_x(x4), .out_y(y4), .frame_done(fd4));

    pool_window_gen d8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_pixel(px8), .out_valid(ov8),
        .pixel1(b1), .pixel2(b2), .pixel3(b3), .pixel4(b4),
        .out_x(x8), .out_y(y8), .frame_done(fd8));

    always @(negedge clk) begin
        if (ov4) q4.push_back('{a1, a2, a3, a4, int'(x4), int'(y4), fd4});
        if (ov8) q8.push_back('{b1, b2, b3, b4, int'(x8), int'(y8), fd8});
        run4 = ov4 ? run4 + 1 : 0;
        run8 = ov8 ? run8 + 1 : 0;
        if (run4 > max4) max4 = run4;
        if (run8 > max8) max8 = run8;
        if (fd4) fdc4++;
        if (fd8) fdc8++;
    end

    task automatic drive4(input logic v, input logic [3:0] p);
        @(negedge clk);
        v4 = v;
        px4 = p;
    endtask

    task automatic idle4(input int n);
        for (int i = 0; i < n; i++) drive4(1'b0, 4'h0);
    endtask

    task automatic clear_mon();
        q4.delete(); q8.delete();
        max4 = 0; max8 = 0; fdc4 = 0; fdc8 = 0;
    endtask

    task automatic compare_q4(input string tag, input win_t e[4], input int base);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (base + k >= q4.size()) begin
                miscompares++;
                $display("FAIL %s win%0d: missing, got %0d windows", tag, k, q4.size());
            end else if ({q4[base+k].p1, q4[base+k].p2, q4[base+k].p3, q4[base+k].p4} !== {e[k].p1, e[k].p2, e[k].p3, e[k].p4}
                         || q4[base+k].x != e[k].x || q4[base+k].y != e[k].y || q4[base+k].fd !== e[k].fd) begin
                miscompares++;
                $display("FAIL %s win%0d: got (%0d,%0d,%0d,%0d) x%0d y%0d fd%0b, want (%0d,%0d,%0d,%0d) x%0d y%0d fd%0b",
                         tag, k, q4[base+k].p1, q4[base+k].p2, q4[base+k].p3, q4[base+k].p4, q4[base+k].x, q4[base+k].y,
                         q4[base+k].fd, e[k].p1, e[k].p2, e[k].p3, e[k].p4, e[k].x, e[k].y, e[k].fd);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ov4, fd4, a1, a2, a3, a4, x4, y4} !== '0) begin
            miscompares++;
            $display("FAIL reset_d4: got %h, want 0", {ov4, fd4, a1, a2, a3, a4, x4, y4});
        end
        vectors++;
        if ({ov8, fd8, b1, b2, b3, b4, x8, y8} !== '0) begin
            miscompares++;
            $display("FAIL reset_d8: got %h, want 0", {ov8, fd8, b1, b2, b3, b4, x8, y8});
        end
    endtask

    task automatic test_frame();
        logic want;
        clear_mon();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i > 0) begin
                want = (i - 1 == 5) || (i - 1 == 7) || (i - 1 == 13) || (i - 1 == 15);
                vectors++;
                if (ov4 !== want) begin
                    miscompares++;
                    $display("FAIL latency after pixel %0d: out_valid=%b want %b", i - 1, ov4, want);
                end
            end
            v4 = i < 16;
            px4 = i < 16 ? 4'(i) : 4'h0;
        end
        idle4(3);
        vectors++;
        if (q4.size() != 4 || fdc4 != 1) begin
            miscompares++;
            $display("FAIL frame_count: windows=%0d frame_done=%0d, want 4 and 1", q4.size(), fdc4);
        end
        compare_q4("frame", exp1, 0);
        vectors++;
        if ({ov4, a1, a2, a3, a4, x4, y4} !== {1'b0, 4'd10, 4'd11, 4'd14, 4'd15, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL hold: got %h, want %h", {ov4, a1, a2, a3, a4, x4, y4},
                     {1'b0, 4'd10, 4'd11, 4'd14, 4'd15, 1'b1, 1'b1});
        end
    endtask

    task automatic test_gaps();
        clear_mon();
        for (int i = 0; i < 16; i++) begin
            drive4(1'b1, 4'(i));
            if (i % 2 == 1) idle4(3);
        end
        idle4(3);
        vectors++;
        if (q4.size() != 4 || max4 != 1) begin
            miscompares++;
            $display("FAIL gaps_shape: windows=%0d max_pulse=%0d, want 4 and 1", q4.size(), max4);
        end
        compare_q4("gaps", exp1, 0);
    endtask

    task automatic test_back_to_back();
        win_t e2[4];
        e2[0] = '{4'd15, 4'd14, 4'd11, 4'd10, 0, 0, 1'b0};
        e2[1] = '{4'd13, 4'd12, 4'd9, 4'd8, 1, 0, 1'b0};
        e2[2] = '{4'd7, 4'd6, 4'd3, 4'd2, 0, 1, 1'b0};
        e2[3] = '{4'd5, 4'd4, 4'd1, 4'd0, 1, 1, 1'b1};
        clear_mon();
        for (int i = 0; i < 32; i++) drive4(1'b1, i < 16 ? 4'(i) : 4'(31 - i));
        idle4(3);
        vectors++;
        if (q4.size() != 8 || fdc4 != 2) begin
            miscompares++;
            $display("FAIL b2b_count: windows=%0d frame_done=%0d, want 8 and 2", q4.size(), fdc4);
        end
        compare_q4("b2b_f1", exp1, 0);
        compare_q4("b2b_f2", e2, 4);
    endtask

    task automatic test_mid_reset();
        clear_mon();
        for (int i = 0; i < 5; i++) drive4(1'b1, 4'(i));
        drive4(1'b1, 4'd5);
        rst = 1'b1;
        drive4(1'b0, 4'd0);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (q4.size() != 0 || {ov4, a1, a2, a3, a4, x4, y4} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_pre: windows=%0d outputs=%h, want 0 and 0", q4.size(), {ov4, a1, a2, a3, a4, x4, y4});
        end
        for (int i = 0; i < 16; i++) drive4(1'b1, 4'(i));
        idle4(3);
        vectors++;
        if (q4.size() != 4) begin
            miscompares++;
            $display("FAIL mid_reset_count: windows=%0d, want 4", q4.size());
        end
        compare_q4("mid_reset", exp1, 0);
    endtask

    task automatic test_ones_8x8();
        clear_mon();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            v8 = 1'b1;
            px8 = 4'hF;
        end
        @(negedge clk);
        v8 = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (q8.size() != 16 || fdc8 != 1 || max8 != 1) begin
            miscompares++;
            $display("FAIL ones_count: windows=%0d frame_done=%0d max_pulse=%0d, want 16 1 1", q8.size(), fdc8, max8);
        end
        for (int k = 0; k < 16 && k < q8.size(); k++) begin
            vectors++;
            if ({q8[k].p1, q8[k].p2, q8[k].p3, q8[k].p4} !== 16'hFFFF || q8[k].x != k % 4 || q8[k].y != k / 4
                || q8[k].fd !== (k == 15)) begin
                miscompares++;
                $display("FAIL ones win%0d: got %h x%0d y%0d fd%0b, want ffff x%0d y%0d fd%0b",
                         k, {q8[k].p1, q8[k].p2, q8[k].p3, q8[k].p4}, q8[k].x, q8[k].y, q8[k].fd, k % 4, k / 4, k == 15);
            end
        end
    endtask

    initial begin
        exp1[0] = '{4'd0, 4'd1, 4'd4, 4'd5, 0, 0, 1'b0};
        exp1[1] = '{4'd2, 4'd3, 4'd6, 4'd7, 1, 0, 1'b0};
        exp1[2] = '{4'd8, 4'd9, 4'd12, 4'd13, 0, 1, 1'b0};
        exp1[3] = '{4'd10, 4'd11, 4'd14, 4'd15, 1, 1, 1'b1};
        test_reset();
        test_frame();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
        test_ones_8x8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
